// File: rtl/p2_stride_seq.sv
// ---------------------------------------------------------------------------
// p2_stride_seq
//
// Power-of-two stride decomposer for the SLDU. A slide stride is accepted
// over a valid/ready handshake and then emitted as one beat per set bit,
// each beat carrying a single one-hot power-of-two component. Bit order is
// LSB-first or MSB-first depending on LsbFirst. A new stride can be accepted
// in the same cycle as the last beat of the previous one, so back-to-back
// strides produce beats on consecutive cycles.
//
// Ports
//   clk_i           clock
//   rst_i           asynchronous reset, active-high
//   flush_i         synchronous abort of the current sequence
//   stride_i        stride to decompose
//   dir_i           direction tag (1 = slide up), passed through
//   stride_valid_i  stride_i/dir_i valid
//   stride_ready_o  a stride can be accepted this cycle
//   p2_o            one-hot power-of-two component (0 for a zero stride)
//   p2_idx_o        bit index of p2_o
//   p2_step_o       beat number within the sequence, from 0
//   p2_dir_o        direction tag captured at accept
//   popc_o          popcount of the accepted stride
//   p2_last_o       final beat of the sequence
//   p2_valid_o      output beat valid
//   p2_ready_i      downstream consumes the beat
//   busy_o          a sequence is in progress
// ---------------------------------------------------------------------------
module p2_stride_seq #(
  parameter int unsigned NrLanes     = 4,
  parameter int unsigned StrideWidth = (8 * NrLanes > 1) ? $clog2(8 * NrLanes) : 1,
  parameter bit          LsbFirst    = 1'b1,
  parameter int unsigned CntW        = $clog2(StrideWidth + 1),
  parameter int unsigned IdxW        = (StrideWidth > 1) ? $clog2(StrideWidth) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [StrideWidth-1:0] stride_i,
  input  logic                   dir_i,
  input  logic                   stride_valid_i,
  output logic                   stride_ready_o,
  output logic [StrideWidth-1:0] p2_o,
  output logic [IdxW-1:0]        p2_idx_o,
  output logic [CntW-1:0]        p2_step_o,
  output logic                   p2_dir_o,
  output logic [CntW-1:0]        popc_o,
  output logic                   p2_last_o,
  output logic                   p2_valid_o,
  input  logic                   p2_ready_i,
  output logic                   busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [StrideWidth-1:0] rem_q, rem_d;     // bits of the stride not yet emitted
  logic                   dir_q, dir_d;
  logic [CntW-1:0]        popc_q, popc_d;
  logic [CntW-1:0]        step_q, step_d;

  logic                   sel_found;
  logic [IdxW-1:0]        sel_idx;
  logic [StrideWidth-1:0] sel_p2;
  logic                   emit;
  logic                   last_beat;
  logic                   fire;
  logic                   accept;

  function automatic logic [CntW-1:0] popcount(input logic [StrideWidth-1:0] v);
    logic [CntW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < StrideWidth; i++) begin
      cnt = cnt + CntW'(v[i]);
    end
    return cnt;
  endfunction

  // -------------------------------------------------------------------------
  // Beat selection: pick the lowest (or highest) set bit of the remaining
  // stride. The scan direction is fixed at elaboration, so only one priority
  // chain is built.
  // -------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default at the top so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < StrideWidth; i++) begin
      if (LsbFirst) begin
        if (!sel_found && rem_q[i]) begin
          sel_found = 1'b1;
          sel_idx   = IdxW'(i);
        end
      end else begin
        if (!sel_found && rem_q[StrideWidth-1-i]) begin
          sel_found = 1'b1;
          sel_idx   = IdxW'(StrideWidth - 1 - i);
        end
      end
    end
  end

  // A zero stride leaves sel_found low, giving the single p2=0, idx=0 beat.
  assign sel_p2    = sel_found ? (StrideWidth'(1) << sel_idx) : '0;
  assign emit      = (state_q == EMIT);
  assign last_beat = emit && ((rem_q ^ sel_p2) == '0);
  assign fire      = emit && p2_ready_i;

  // Ready deliberately ignores flush_i: during a flush it may read 1, but the
  // accept term below still blocks the handshake.
  assign stride_ready_o = (state_q == IDLE) || (fire && last_beat);
  assign accept         = stride_valid_i && stride_ready_o && !flush_i;

  // -------------------------------------------------------------------------
  // Next-state logic. Priority: flush, then accept (which in EMIT can only
  // coincide with the last beat transferring), then a plain beat transfer.
  // Registers are cleared whenever the block drops to IDLE, so all beat
  // outputs read 0 while idle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    popc_d  = popc_q;
    step_d  = step_q;

    if (flush_i) begin
      state_d = IDLE;
      rem_d   = '0;
      dir_d   = 1'b0;
      popc_d  = '0;
      step_d  = '0;
    end else if (accept) begin
      state_d = EMIT;
      rem_d   = stride_i;
      dir_d   = dir_i;
      popc_d  = popcount(stride_i);
      step_d  = '0;
    end else if (fire) begin
      if (last_beat) begin
        state_d = IDLE;
        rem_d   = '0;
        dir_d   = 1'b0;
        popc_d  = '0;
        step_d  = '0;
      end else begin
        rem_d  = rem_q ^ sel_p2;
        step_d = step_q + CntW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      popc_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      popc_q  <= popc_d;
      step_q  <= step_d;
    end
  end

  // All beat outputs derive from registered state only; while the beat is
  // stalled nothing they depend on changes, so they hold stable.
  assign p2_o       = sel_p2;
  assign p2_idx_o   = sel_idx;
  assign p2_step_o  = step_q;
  assign p2_dir_o   = dir_q;
  assign popc_o     = popc_q;
  assign p2_last_o  = last_beat;
  assign p2_valid_o = emit;
  assign busy_o     = emit;

endmodule

// File: tb/tb_p2_stride_seq.sv
// ---------------------------------------------------------------------------
// tb_p2_stride_seq
//
// Drives an LSB-first and an MSB-first instance with identical stimulus.
// The reference model turns each accepted stride into a queue of expected
// beats (set bits in the required order) and compares the head of the queue
// against each instance every cycle.
// ---------------------------------------------------------------------------
module tb_p2_stride_seq;

  localparam int SW   = 5;
  localparam int IDXW = 3;
  localparam int CNTW = 3;

  typedef struct {
    logic [SW-1:0] p2;
    int            idx;
    int            step;
    logic          dir;
    int            popc;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [SW-1:0] stride;
  logic          dir;
  logic          stride_valid;
  logic          p2_ready;

  logic            l_stride_ready, l_dir, l_last, l_valid, l_busy;
  logic [SW-1:0]   l_p2;
  logic [IDXW-1:0] l_idx;
  logic [CNTW-1:0] l_step, l_popc;

  logic            m_stride_ready, m_dir, m_last, m_valid, m_busy;
  logic [SW-1:0]   m_p2;
  logic [IDXW-1:0] m_idx;
  logic [CNTW-1:0] m_step, m_popc;

  beat_t q_lsb[$];
  beat_t q_msb[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  p2_stride_seq #(.NrLanes(4), .LsbFirst(1'b1)) u_lsb (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stride_i(stride), .dir_i(dir),
    .stride_valid_i(stride_valid), .stride_ready_o(l_stride_ready),
    .p2_o(l_p2), .p2_idx_o(l_idx), .p2_step_o(l_step), .p2_dir_o(l_dir),
    .popc_o(l_popc), .p2_last_o(l_last), .p2_valid_o(l_valid),
    .p2_ready_i(p2_ready), .busy_o(l_busy)
  );

  p2_stride_seq #(.NrLanes(4), .LsbFirst(1'b0)) u_msb (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stride_i(stride), .dir_i(dir),
    .stride_valid_i(stride_valid), .stride_ready_o(m_stride_ready),
    .p2_o(m_p2), .p2_idx_o(m_idx), .p2_step_o(m_step), .p2_dir_o(m_dir),
    .popc_o(m_popc), .p2_last_o(m_last), .p2_valid_o(m_valid),
    .p2_ready_i(p2_ready), .busy_o(m_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: a stride becomes its list of set bits, ascending for
  // LSB-first and descending for MSB-first; a zero stride is one empty beat.
  task automatic push_seq(input logic [SW-1:0] s, input logic d);
    int pc;
    int k;
    beat_t b;
    pc = 0;
    for (int i = 0; i < SW; i++) if (s[i]) pc++;
    if (pc == 0) begin
      b = '{p2: '0, idx: 0, step: 0, dir: d, popc: 0, last: 1'b1};
      q_lsb.push_back(b);
      q_msb.push_back(b);
    end else begin
      k = 0;
      for (int i = 0; i < SW; i++) begin
        if (s[i]) begin
          b = '{p2: SW'(1) << i, idx: i, step: k, dir: d, popc: pc, last: (k == pc - 1)};
          q_lsb.push_back(b);
          k++;
        end
      end
      k = 0;
      for (int i = SW - 1; i >= 0; i--) begin
        if (s[i]) begin
          b = '{p2: SW'(1) << i, idx: i, step: k, dir: d, popc: pc, last: (k == pc - 1)};
          q_msb.push_back(b);
          k++;
        end
      end
    end
  endtask

  task automatic check_side(input string who, input bit has, input beat_t e,
                            input logic v, input logic bz, input logic [SW-1:0] p2,
                            input logic [IDXW-1:0] idx, input logic [CNTW-1:0] step,
                            input logic d, input logic [CNTW-1:0] popc, input logic last);
    check({who, "_valid"}, 32'(v), 32'(has));
    check({who, "_busy"}, 32'(bz), 32'(has));
    if (has) begin
      check({who, "_p2"}, 32'(p2), 32'(e.p2));
      check({who, "_idx"}, 32'(idx), 32'(e.idx));
      check({who, "_step"}, 32'(step), 32'(e.step));
      check({who, "_dir"}, 32'(d), 32'(e.dir));
      check({who, "_popc"}, 32'(popc), 32'(e.popc));
      check({who, "_last"}, 32'(last), 32'(e.last));
    end
  endtask

  task automatic check_all();
    beat_t e_l;
    beat_t e_m;
    e_l = '{p2: '0, idx: 0, step: 0, dir: 1'b0, popc: 0, last: 1'b0};
    e_m = e_l;
    if (q_lsb.size() != 0) e_l = q_lsb[0];
    if (q_msb.size() != 0) e_m = q_msb[0];
    check_side("lsb", q_lsb.size() != 0, e_l, l_valid, l_busy, l_p2, l_idx, l_step,
               l_dir, l_popc, l_last);
    check_side("msb", q_msb.size() != 0, e_m, m_valid, m_busy, m_p2, m_idx, m_step,
               m_dir, m_popc, m_last);
  endtask

  task automatic check_reset_values(input string who);
    check({who, "_rst_ready_l"}, 32'(l_stride_ready), 32'd1);
    check({who, "_rst_ready_m"}, 32'(m_stride_ready), 32'd1);
    check({who, "_rst_valid_l"}, 32'(l_valid), 32'd0);
    check({who, "_rst_valid_m"}, 32'(m_valid), 32'd0);
    check({who, "_rst_busy_l"}, 32'(l_busy), 32'd0);
    check({who, "_rst_p2_l"}, 32'(l_p2), 32'd0);
    check({who, "_rst_p2_m"}, 32'(m_p2), 32'd0);
    check({who, "_rst_idx_l"}, 32'(l_idx), 32'd0);
    check({who, "_rst_step_l"}, 32'(l_step), 32'd0);
    check({who, "_rst_dir_l"}, 32'(l_dir), 32'd0);
    check({who, "_rst_popc_l"}, 32'(l_popc), 32'd0);
    check({who, "_rst_last_l"}, 32'(l_last), 32'd0);
    check({who, "_rst_last_m"}, 32'(m_last), 32'd0);
  endtask

  // One clock cycle: check outputs, apply inputs, check the combinational
  // ready, then advance the model to what the coming edge should produce.
  task automatic cycle(input logic sv, input logic [SW-1:0] s, input logic d,
                       input logic rdy, input logic fl);
    bit exp_rdy;
    @(negedge clk);
    check_all();
    stride_valid = sv;
    stride       = s;
    dir          = d;
    p2_ready     = rdy;
    flush        = fl;
    #1;
    exp_rdy = (q_lsb.size() == 0);
    if (q_lsb.size() != 0) begin
      if (rdy && q_lsb[0].last) exp_rdy = 1'b1;
    end
    check("lsb_stride_ready", 32'(l_stride_ready), 32'(exp_rdy));
    check("msb_stride_ready", 32'(m_stride_ready), 32'(exp_rdy));
    if (fl) begin
      q_lsb.delete();
      q_msb.delete();
    end else begin
      if (q_lsb.size() != 0 && rdy) begin
        void'(q_lsb.pop_front());
        void'(q_msb.pop_front());
      end
      if (sv && exp_rdy) push_seq(s, d);
    end
  endtask

  task automatic reset_mid(input string who);
    @(negedge clk);
    check_all();
    stride_valid = 1'b0;
    flush        = 1'b0;
    rst          = 1'b1;
    #1;
    check_reset_values(who);
    q_lsb.delete();
    q_msb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    stride       = '0;
    dir          = 1'b0;
    stride_valid = 1'b0;
    p2_ready     = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("init");
    rst = 1'b0;

    // T1/T2: stride 10110, dir 1, downstream always ready.
    cycle(1'b1, 5'b10110, 1'b1, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);

    // T3: stride 01001 with the first beat stalled for 3 cycles.
    cycle(1'b1, 5'b01001, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);

    // T4: zero stride.
    cycle(1'b1, 5'b00000, 1'b1, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);

    // T5: 00011 then 10000 offered on the last beat, accepted without a bubble.
    cycle(1'b1, 5'b00011, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 5'b10000, 1'b1, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);

    // T6: all-ones stride flushed at step 2 with a stride offered; then reset.
    cycle(1'b1, 5'b11111, 1'b1, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 5'b00111, 1'b0, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 5'b11111, 1'b1, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
    reset_mid("mid");
    repeat (2) cycle(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);

    // All-ones stride run to completion: SW beats.
    cycle(1'b1, 5'b11111, 1'b0, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [SW-1:0] s;
      int            sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      s = '0;
      else if (sel == 1) s = '1;
      else               s = SW'($urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) begin
        reset_mid("rnd");
      end else begin
        cycle(logic'($urandom_range(0, 99) < 60), s, logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 99) < 70), logic'($urandom_range(0, 99) < 3));
      end
    end

    repeat (8) cycle(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
